// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared command encodings, fetch-controller states and the
//               halt sentinel word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_RUN  = 2'd1,
        CMD_STEP = 2'd2,
        CMD_HALT = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Loads instruction memory, then runs or single-steps the fetch
//               stage until a halt word or HALT command is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
    import mips_pkg::*;
#(
    parameter int SIZE            = 32,
    parameter int MAX_INSTRUCTION = 64,
    localparam int AW             = $clog2(MAX_INSTRUCTION)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cmd_valid,
    input  logic [1:0]      i_cmd,
    input  logic [AW:0]     i_cmd_arg,
    output logic            o_cmd_ready,
    input  logic            i_load_valid,
    input  logic [SIZE-1:0] i_load_data,
    output logic            o_load_ready,
    input  logic [SIZE-1:0] i_instruction,
    output logic            o_stall,
    output logic            o_pc_rst,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [SIZE-1:0] o_mem_wdata,
    output logic            o_done,
    output logic            o_err,
    output logic [SIZE-1:0] o_cycles
);

    localparam logic [AW:0] MAX_ARG = (AW+1)'(MAX_INSTRUCTION);

    state_e          r_state;
    state_e          w_state_next;
    logic [AW:0]     r_remaining;
    logic [AW-1:0]   r_ptr;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [SIZE-1:0] r_mem_wdata;
    logic            r_pc_rst;
    logic            r_err;
    logic [SIZE-1:0] r_cycles;

    logic w_idle_like;
    logic w_cmd_accept;
    logic w_load_accept;
    logic w_arg_bad;
    logic w_halt_word;
    logic w_load_start;
    logic w_load_err;
    logic w_run_start;

    always_comb begin
        w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE);
        w_halt_word   = (i_instruction == SIZE'(HALT_WORD));
        w_arg_bad     = (i_cmd_arg == '0) || (i_cmd_arg > MAX_ARG);

        o_cmd_ready = 1'b0;
        if (w_idle_like)
            o_cmd_ready = 1'b1;
        else if (r_state == ST_RUN)
            o_cmd_ready = (i_cmd == CMD_HALT);

        o_load_ready  = (r_state == ST_LOAD);
        w_cmd_accept  = i_cmd_valid && o_cmd_ready;
        w_load_accept = i_load_valid && o_load_ready;

        w_load_start = w_cmd_accept && w_idle_like && (i_cmd == CMD_LOAD) && !w_arg_bad;
        w_load_err   = w_cmd_accept && w_idle_like && (i_cmd == CMD_LOAD) && w_arg_bad;
        w_run_start  = w_cmd_accept && w_idle_like && (i_cmd == CMD_RUN);

        o_stall = !(((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_halt_word);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_cmd_accept) begin
                    case (i_cmd)
                        CMD_LOAD: if (!w_arg_bad) w_state_next = ST_LOAD;
                        CMD_RUN:  w_state_next = ST_RUN;
                        CMD_STEP: w_state_next = ST_STEP;
                        default:  w_state_next = r_state;
                    endcase
                end
            end
            // Leaving on the last accepted word means the final write cycle
            // already sees IDLE with load_ready low.
            ST_LOAD: if (w_load_accept && (r_remaining == (AW+1)'(1))) w_state_next = ST_IDLE;
            ST_RUN:  if (w_halt_word || w_cmd_accept) w_state_next = ST_DONE;
            ST_STEP: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_ptr       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc_rst    <= 1'b0;
            r_err       <= 1'b0;
            r_cycles    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= w_load_accept;
            r_pc_rst <= w_run_start;
            r_err    <= w_load_err;

            if (w_load_start) begin
                r_remaining <= i_cmd_arg;
                r_ptr       <= '0;
            end else if (w_load_accept) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= i_load_data;
                r_ptr       <= r_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end

            if (w_run_start)
                r_cycles <= '0;
            else if (!o_stall && (r_cycles != '1))
                r_cycles <= r_cycles + 1'b1;
        end
    end

    assign o_pc_rst    = r_pc_rst;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_done      = (r_state == ST_DONE);
    assign o_err       = r_err;
    assign o_cycles    = r_cycles;

endmodule

`default_nettype wire
